// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: latches one EX/DM request, runs the req/ack
// handshake with a timeout, stalls the pipeline, and returns load data.
module dm_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [ADDR_W-1:0] Mem_address,
    input  logic [DATA_W-1:0] Write_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] read_data_out,
    output logic              read_valid,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    // Handshake: mem_req is held high for every ACCESS cycle; the memory
    // completes by pulsing mem_ack for one cycle with mem_rdata valid alongside.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              is_read_q, is_read_d;
    logic              err_q, err_d;
    logic              access;

    assign access = mem_read_in | mem_write_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        is_read_d = is_read_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    addr_d    = Mem_address;
                    wdata_d   = Write_data_in;
                    we_d      = mem_write_in;
                    // A simultaneous read+write is a write and never reports load data.
                    is_read_d = mem_read_in & ~mem_write_in;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!mem_ack) cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    if (is_read_q) rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            is_read_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            is_read_q <= is_read_d;
            err_q     <= err_d;
        end
    end

    // The IDLE stall term is gated by reset so every output is 0 while reset is held.
    assign mem_req       = (state_q == S_ACCESS);
    assign stall         = (state_q == S_ACCESS) | ((state_q == S_IDLE) & access & reset);
    assign read_valid    = (state_q == S_DONE) & is_read_q;
    assign timeout_err   = (state_q == S_DONE) & err_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign read_data_out = rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus random
// transactions checked against a per-transaction behavioural model.
module tb_dm_access_ctrl;

    localparam int  ADDR_W  = 32;
    localparam int  DATA_W  = 32;
    localparam int  TIMEOUT = 15;
    localparam int  CNT_W   = 4;
    localparam time CLK_P   = 10;

    logic              clk;
    logic              reset;
    logic              mem_read_in;
    logic              mem_write_in;
    logic [ADDR_W-1:0] Mem_address;
    logic [DATA_W-1:0] Write_data_in;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic [DATA_W-1:0] read_data_out;
    logic              read_valid;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    dm_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .Mem_address  (Mem_address),
        .Write_data_in(Write_data_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .read_data_out(read_data_out),
        .read_valid   (read_valid),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_rdata;
    time               cur_req_t;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model: a transaction acked in ACCESS cycle k (1..TIMEOUT) holds mem_req k
    // cycles and stall k+1; otherwise it aborts after TIMEOUT cycles with zero data.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                              input int ack_at, input logic [DATA_W-1:0] rdata,
                              input bit disturb, input bit stray);
        bit   is_read = rd && !wr;
        bit   acked   = (ack_at >= 1) && (ack_at <= TIMEOUT);
        int   exp_req = acked ? ack_at : TIMEOUT;
        int   req_cnt = 0;
        int   stall_cnt = 0;
        logic [DATA_W-1:0] exp_data;
        if (acked && is_read) model_rdata = rdata;
        else if (!acked)      model_rdata = '0;
        if (is_read) exp_q.push_back(model_rdata);

        @(negedge clk);
        check("idle_req", mem_req, 1'b0);
        check("idle_rv", read_valid, 1'b0);
        check("idle_to", timeout_err, 1'b0);
        mem_read_in   = rd;
        mem_write_in  = wr;
        Mem_address   = addr;
        Write_data_in = wdata;
        mem_ack       = stray;
        mem_rdata     = $urandom;
        #1;
        if (stall) stall_cnt++;

        @(negedge clk);
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        cur_req_t    = $time;
        while (mem_req && req_cnt < TIMEOUT + 3) begin
            req_cnt++;
            if (stall) stall_cnt++;
            check("addr_hold", mem_addr, addr);
            check("wdata_hold", mem_wdata, wdata);
            check("we_hold", mem_we, wr);
            if (disturb) begin
                Mem_address   = $urandom;
                Write_data_in = $urandom;
            end
            mem_ack   = (req_cnt == ack_at);
            mem_rdata = mem_ack ? rdata : DATA_W'($urandom);
            @(negedge clk);
            mem_ack = 1'b0;
        end

        check("req_cycles", req_cnt, exp_req);
        check("stall_cycles", stall_cnt, exp_req + 1);
        check("done_stall", stall, 1'b0);
        check("done_rv", read_valid, is_read);
        check("done_to", timeout_err, !acked);
        check("rdata_model", read_data_out, model_rdata);
        if (is_read && exp_q.size() > 0) begin
            exp_data = exp_q.pop_front();
            check("rv_data", read_data_out, exp_data);
        end
        mem_ack   = stray;
        mem_rdata = $urandom;
    endtask

    initial begin
        time t1;
        reset         = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        Mem_address   = '0;
        Write_data_in = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        model_rdata   = '0;
        cur_req_t     = 0;

        #3;
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_rdata", read_data_out, '0);
        check("rst_state", dbg_state, 2'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0);
        run_access(1'b0, 1'b1, 32'h80, 32'h12345678, 4, 32'h0, 1'b0, 1'b0);
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_access(1'b1, 1'b0, 32'h104, 32'h0, TIMEOUT, 32'hA5A5A5A5, 1'b0, 1'b0);
        run_access(1'b1, 1'b1, 32'h108, 32'hCAFE, 2, 32'h1111, 1'b0, 1'b0);

        run_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h11111111, 1'b1, 1'b0);
        t1 = cur_req_t;
        run_access(1'b1, 1'b0, 32'h14, 32'h0, 1, 32'h22222222, 1'b1, 1'b0);
        check("b2b_gap", (cur_req_t - t1) / CLK_P, 3);

        // reset in the 2nd ACCESS cycle, with the load request still asserted
        @(negedge clk);
        mem_ack       = 1'b0;
        mem_read_in   = 1'b1;
        Mem_address   = 32'h200;
        repeat (2) @(negedge clk);
        check("mid_req_pre", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_req", mem_req, 1'b0);
        check("mid_stall", stall, 1'b0);
        check("mid_addr", mem_addr, '0);
        check("mid_rdata", read_data_out, '0);
        model_rdata = '0;
        @(negedge clk);
        mem_read_in = 1'b0;
        reset       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rv", read_valid, 1'b0);
            check("post_rst_to", timeout_err, 1'b0);
            check("post_rst_req", mem_req, 1'b0);
            check("post_rst_state", dbg_state, 2'd0);
        end

        for (int i = 0; i < 25; i++) begin
            logic rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            run_access(rd, wr, ADDR_W'($urandom), DATA_W'($urandom),
                       $urandom_range(0, TIMEOUT + 2), DATA_W'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("end_idle_stall", stall, 1'b0);
        check("end_req", mem_req, 1'b0);
        check("end_rdata", read_data_out, model_rdata);
        check("end_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
